// File: rtl/memory_access.sv
// Memory-access pipeline stage: issues loads/stores on a req/ack data bus with
// big-endian byte-lane steering, and passes non-memory results to writeback.
module memory_access (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_exec_stall,
    input  logic        i_fetch_stall,
    output logic        o_mem_stall,
    input  logic [5:0]  i_op,
    input  logic [4:0]  i_dst_gpr,
    input  logic [31:0] i_result,
    input  logic [31:0] i_mem_data,
    output logic [31:0] o_dbus_addr,
    output logic        o_dbus_rd,
    output logic        o_dbus_wr,
    output logic [3:0]  o_dbus_ben,
    output logic [31:0] o_dbus_wdata,
    input  logic [31:0] i_dbus_rdata,
    input  logic        i_dbus_ack,
    output logic [4:0]  o_rd_no,
    output logic [31:0] o_rd_val,
    output logic        o_rd_wr,
    output logic        o_addr_err,
    output logic [31:0] o_err_addr
);

    localparam logic [5:0] OP_LB  = 6'h20;
    localparam logic [5:0] OP_LH  = 6'h21;
    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_LBU = 6'h24;
    localparam logic [5:0] OP_LHU = 6'h25;
    localparam logic [5:0] OP_SB  = 6'h28;
    localparam logic [5:0] OP_SH  = 6'h29;
    localparam logic [5:0] OP_SW  = 6'h2B;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t      state_q;
    logic [5:0]  memOp_q;
    logic [4:0]  dstGpr_q;
    logic [1:0]  byteOff_q;

    logic        coreStall;
    logic        isLoad, isStore, misaligned;
    logic [3:0]  ben_d;
    logic [31:0] wdata_d;
    logic [31:0] loadVal_d;
    logic [31:0] laneShifted;
    logic [7:0]  byteVal;
    logic [15:0] halfVal;

    assign coreStall   = o_mem_stall | i_exec_stall | i_fetch_stall;
    assign o_mem_stall = (state_q == BUSY);

    // Decode the incoming op: lane enables, store replication and alignment check.
    always_comb begin
        isLoad     = 1'b0;
        isStore    = 1'b0;
        misaligned = 1'b0;
        ben_d      = 4'b0000;
        wdata_d    = i_mem_data;
        case (i_op)
            OP_LB, OP_LBU, OP_SB: begin
                ben_d   = 4'b1000 >> i_result[1:0];
                wdata_d = {4{i_mem_data[7:0]}};
            end
            OP_LH, OP_LHU, OP_SH: begin
                ben_d      = i_result[1] ? 4'b0011 : 4'b1100;
                wdata_d    = {2{i_mem_data[15:0]}};
                misaligned = i_result[0];
            end
            OP_LW, OP_SW: begin
                ben_d      = 4'b1111;
                misaligned = |i_result[1:0];
            end
            default: ;
        endcase
        isLoad  = (i_op == OP_LB) || (i_op == OP_LH) || (i_op == OP_LW) ||
                  (i_op == OP_LBU) || (i_op == OP_LHU);
        isStore = (i_op == OP_SB) || (i_op == OP_SH) || (i_op == OP_SW);
    end

    // Byte k of a big-endian word sits 8*(3-k) bits above bit 0.
    always_comb begin
        laneShifted = i_dbus_rdata >> {~byteOff_q, 3'b000};
        byteVal     = laneShifted[7:0];
        halfVal     = byteOff_q[1] ? i_dbus_rdata[15:0] : i_dbus_rdata[31:16];
        case (memOp_q)
            OP_LB:   loadVal_d = {{24{byteVal[7]}}, byteVal};
            OP_LBU:  loadVal_d = {24'h0, byteVal};
            OP_LH:   loadVal_d = {{16{halfVal[15]}}, halfVal};
            OP_LHU:  loadVal_d = {16'h0, halfVal};
            default: loadVal_d = i_dbus_rdata;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            memOp_q      <= 6'h0;
            dstGpr_q     <= 5'h0;
            byteOff_q    <= 2'h0;
            o_dbus_addr  <= 32'h0;
            o_dbus_rd    <= 1'b0;
            o_dbus_wr    <= 1'b0;
            o_dbus_ben   <= 4'h0;
            o_dbus_wdata <= 32'h0;
            o_rd_no      <= 5'h0;
            o_rd_val     <= 32'h0;
            o_rd_wr      <= 1'b0;
            o_addr_err   <= 1'b0;
            o_err_addr   <= 32'h0;
        end else begin
            o_rd_wr    <= 1'b0;
            o_addr_err <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (!coreStall) begin
                        if ((isLoad || isStore) && misaligned) begin
                            o_addr_err <= 1'b1;
                            o_err_addr <= i_result;
                        end else if (isLoad || isStore) begin
                            o_dbus_addr <= {i_result[31:2], 2'b00};
                            o_dbus_rd   <= isLoad;
                            o_dbus_wr   <= isStore;
                            o_dbus_ben  <= ben_d;
                            if (isStore)
                                o_dbus_wdata <= wdata_d;
                            memOp_q   <= i_op;
                            dstGpr_q  <= i_dst_gpr;
                            byteOff_q <= i_result[1:0];
                            state_q   <= BUSY;
                        end else begin
                            o_rd_no  <= i_dst_gpr;
                            o_rd_val <= i_result;
                            o_rd_wr  <= (i_dst_gpr != 5'h0);
                        end
                    end
                end
                BUSY: begin
                    if (i_dbus_ack) begin
                        o_dbus_rd  <= 1'b0;
                        o_dbus_wr  <= 1'b0;
                        o_dbus_ben <= 4'h0;
                        state_q    <= IDLE;
                        if (o_dbus_rd) begin
                            o_rd_no  <= dstGpr_q;
                            o_rd_val <= loadVal_d;
                            o_rd_wr  <= (dstGpr_q != 5'h0);
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_memory_access.sv
// Directed self-checking bench for the memory_access stage.
module tb_memory_access;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_exec_stall, i_fetch_stall;
    logic        o_mem_stall;
    logic [5:0]  i_op;
    logic [4:0]  i_dst_gpr;
    logic [31:0] i_result, i_mem_data;
    logic [31:0] o_dbus_addr;
    logic        o_dbus_rd, o_dbus_wr;
    logic [3:0]  o_dbus_ben;
    logic [31:0] o_dbus_wdata;
    logic [31:0] i_dbus_rdata;
    logic        i_dbus_ack;
    logic [4:0]  o_rd_no;
    logic [31:0] o_rd_val;
    logic        o_rd_wr, o_addr_err;
    logic [31:0] o_err_addr;

    int vectors = 0;
    int errors  = 0;

    memory_access dut (
        .clk(clk), .rst(rst),
        .i_exec_stall(i_exec_stall), .i_fetch_stall(i_fetch_stall),
        .o_mem_stall(o_mem_stall),
        .i_op(i_op), .i_dst_gpr(i_dst_gpr), .i_result(i_result), .i_mem_data(i_mem_data),
        .o_dbus_addr(o_dbus_addr), .o_dbus_rd(o_dbus_rd), .o_dbus_wr(o_dbus_wr),
        .o_dbus_ben(o_dbus_ben), .o_dbus_wdata(o_dbus_wdata),
        .i_dbus_rdata(i_dbus_rdata), .i_dbus_ack(i_dbus_ack),
        .o_rd_no(o_rd_no), .o_rd_val(o_rd_val), .o_rd_wr(o_rd_wr),
        .o_addr_err(o_addr_err), .o_err_addr(o_err_addr)
    );

    always #5 clk = ~clk;

    // Advance one edge and sample 1 ns after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // A bubble is a non-memory op to r0: it never strobes writeback.
    task automatic set_op(input logic [5:0] op, input logic [4:0] dst,
                          input logic [31:0] res, input logic [31:0] data);
        i_op = op; i_dst_gpr = dst; i_result = res; i_mem_data = data;
    endtask

    task automatic test_reset();
        vectors++;
        if ({o_mem_stall, o_dbus_rd, o_dbus_wr, o_dbus_ben, o_dbus_addr, o_dbus_wdata,
             o_rd_no, o_rd_val, o_rd_wr, o_addr_err, o_err_addr} !== '0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: got stall=%b rd=%b wr=%b ben=%h addr=%h rdwr=%b required all 0",
                     o_mem_stall, o_dbus_rd, o_dbus_wr, o_dbus_ben, o_dbus_addr, o_rd_wr);
        end
    endtask

    task automatic test_passthrough();
        set_op(6'h00, 5'd5, 32'h1234_5678, 32'h0);
        tick();
        set_op(6'h00, 5'd0, 32'h0, 32'h0);
        vectors++;
        if ({o_rd_wr, o_rd_no, o_rd_val, o_dbus_rd, o_dbus_wr, o_mem_stall} !==
            {1'b1, 5'd5, 32'h1234_5678, 1'b0, 1'b0, 1'b0}) begin
            errors++;
            $display("[TB] FAIL passthrough: got wr=%b no=%0d val=%h rd=%b dwr=%b required 1 5 12345678 0 0",
                     o_rd_wr, o_rd_no, o_rd_val, o_dbus_rd, o_dbus_wr);
        end
        tick();
        vectors++;
        if (o_rd_wr !== 1'b0) begin
            errors++;
            $display("[TB] FAIL passthrough_pulse: got rd_wr=%b required 0", o_rd_wr);
        end
        set_op(6'h00, 5'd0, 32'h9999_0000, 32'h0);
        tick();
        vectors++;
        if ({o_rd_wr, o_rd_val} !== {1'b0, 32'h9999_0000}) begin
            errors++;
            $display("[TB] FAIL passthrough_r0: got rd_wr=%b val=%h required 0 99990000", o_rd_wr, o_rd_val);
        end
        set_op(6'h00, 5'd0, 32'h0, 32'h0);
        tick();
    endtask

    task automatic test_lw_waits();
        set_op(6'h23, 5'd8, 32'h0000_0100, 32'h0);
        tick();
        set_op(6'h00, 5'd0, 32'h0, 32'h0);
        for (int c = 0; c < 3; c++) begin
            vectors++;
            if ({o_dbus_rd, o_dbus_wr, o_dbus_addr, o_dbus_ben, o_mem_stall, o_rd_wr} !==
                {1'b1, 1'b0, 32'h100, 4'b1111, 1'b1, 1'b0}) begin
                errors++;
                $display("[TB] FAIL lw_busy_%0d: got rd=%b addr=%h ben=%b stall=%b rdwr=%b required 1 100 1111 1 0",
                         c, o_dbus_rd, o_dbus_addr, o_dbus_ben, o_mem_stall, o_rd_wr);
            end
            if (c == 2) begin
                i_dbus_ack = 1'b1;
                i_dbus_rdata = 32'hDEAD_BEEF;
            end
            tick();
        end
        i_dbus_ack = 1'b0;
        vectors++;
        if ({o_rd_wr, o_rd_no, o_rd_val, o_dbus_rd, o_dbus_ben, o_mem_stall} !==
            {1'b1, 5'd8, 32'hDEAD_BEEF, 1'b0, 4'b0000, 1'b0}) begin
            errors++;
            $display("[TB] FAIL lw_writeback: got wr=%b no=%0d val=%h rd=%b ben=%b stall=%b required 1 8 deadbeef 0 0000 0",
                     o_rd_wr, o_rd_no, o_rd_val, o_dbus_rd, o_dbus_ben, o_mem_stall);
        end
        i_dbus_ack = 1'b1;
        tick();
        i_dbus_ack = 1'b0;
        vectors++;
        if ({o_rd_wr, o_dbus_rd, o_mem_stall} !== 3'b000) begin
            errors++;
            $display("[TB] FAIL idle_ack_ignored: got rdwr=%b rd=%b stall=%b required 0 0 0",
                     o_rd_wr, o_dbus_rd, o_mem_stall);
        end
    endtask

    task automatic test_load_lanes();
        logic [5:0]  ops  [4] = '{6'h20, 6'h24, 6'h21, 6'h25};
        logic [31:0] addrs[4] = '{32'h103, 32'h103, 32'h102, 32'h100};
        logic [31:0] rdat [4] = '{32'h0102_0380, 32'h0102_0380, 32'h7FFF_8380, 32'h7FFF_8380};
        logic [3:0]  bens [4] = '{4'b0001, 4'b0001, 4'b0011, 4'b1100};
        logic [31:0] vals [4] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_8380, 32'h0000_7FFF};
        for (int i = 0; i < 4; i++) begin
            set_op(ops[i], 5'(3 + i), addrs[i], 32'h0);
            tick();
            set_op(6'h00, 5'd0, 32'h0, 32'h0);
            vectors++;
            if ({o_dbus_rd, o_dbus_addr, o_dbus_ben} !== {1'b1, 32'h100, bens[i]}) begin
                errors++;
                $display("[TB] FAIL load_req_%0d: got rd=%b addr=%h ben=%b required 1 100 %b",
                         i, o_dbus_rd, o_dbus_addr, o_dbus_ben, bens[i]);
            end
            i_dbus_ack = 1'b1;
            i_dbus_rdata = rdat[i];
            tick();
            i_dbus_ack = 1'b0;
            vectors++;
            if ({o_rd_wr, o_rd_no, o_rd_val} !== {1'b1, 5'(3 + i), vals[i]}) begin
                errors++;
                $display("[TB] FAIL load_val_%0d: got wr=%b no=%0d val=%h required 1 %0d %h",
                         i, o_rd_wr, o_rd_no, o_rd_val, 3 + i, vals[i]);
            end
        end
        tick();
    endtask

    task automatic test_stores();
        set_op(6'h29, 5'd6, 32'h0000_0202, 32'hAAAA_1234);
        tick();
        set_op(6'h00, 5'd0, 32'h0, 32'h0);
        vectors++;
        if ({o_dbus_wr, o_dbus_rd, o_dbus_addr, o_dbus_ben, o_dbus_wdata, o_mem_stall} !==
            {1'b1, 1'b0, 32'h200, 4'b0011, 32'h1234_1234, 1'b1}) begin
            errors++;
            $display("[TB] FAIL sh_req: got wr=%b rd=%b addr=%h ben=%b wdata=%h required 1 0 200 0011 12341234",
                     o_dbus_wr, o_dbus_rd, o_dbus_addr, o_dbus_ben, o_dbus_wdata);
        end
        i_dbus_ack = 1'b1;
        tick();
        i_dbus_ack = 1'b0;
        vectors++;
        if ({o_dbus_wr, o_dbus_ben, o_rd_wr, o_mem_stall} !== {1'b0, 4'b0000, 1'b0, 1'b0}) begin
            errors++;
            $display("[TB] FAIL sh_done: got wr=%b ben=%b rdwr=%b stall=%b required 0 0000 0 0",
                     o_dbus_wr, o_dbus_ben, o_rd_wr, o_mem_stall);
        end
        set_op(6'h28, 5'd6, 32'h0000_0301, 32'h0000_00AB);
        tick();
        set_op(6'h00, 5'd0, 32'h0, 32'h0);
        vectors++;
        if ({o_dbus_wr, o_dbus_addr, o_dbus_ben, o_dbus_wdata} !==
            {1'b1, 32'h300, 4'b0100, 32'hABAB_ABAB}) begin
            errors++;
            $display("[TB] FAIL sb_req: got wr=%b addr=%h ben=%b wdata=%h required 1 300 0100 abababab",
                     o_dbus_wr, o_dbus_addr, o_dbus_ben, o_dbus_wdata);
        end
        i_dbus_ack = 1'b1;
        tick();
        i_dbus_ack = 1'b0;
        tick();
    endtask

    task automatic test_misaligned();
        set_op(6'h23, 5'd9, 32'h0000_0102, 32'h0);
        tick();
        set_op(6'h00, 5'd0, 32'h0, 32'h0);
        vectors++;
        if ({o_addr_err, o_err_addr, o_dbus_rd, o_mem_stall, o_rd_wr} !==
            {1'b1, 32'h102, 1'b0, 1'b0, 1'b0}) begin
            errors++;
            $display("[TB] FAIL misaligned_lw: got err=%b eaddr=%h rd=%b stall=%b rdwr=%b required 1 102 0 0 0",
                     o_addr_err, o_err_addr, o_dbus_rd, o_mem_stall, o_rd_wr);
        end
        tick();
        vectors++;
        if ({o_addr_err, o_dbus_rd} !== 2'b00) begin
            errors++;
            $display("[TB] FAIL misaligned_pulse: got err=%b rd=%b required 0 0", o_addr_err, o_dbus_rd);
        end
        set_op(6'h29, 5'd0, 32'h0000_0205, 32'h1);
        tick();
        set_op(6'h00, 5'd0, 32'h0, 32'h0);
        vectors++;
        if ({o_addr_err, o_err_addr, o_dbus_wr} !== {1'b1, 32'h205, 1'b0}) begin
            errors++;
            $display("[TB] FAIL misaligned_sh: got err=%b eaddr=%h wr=%b required 1 205 0",
                     o_addr_err, o_err_addr, o_dbus_wr);
        end
        tick();
    endtask

    task automatic test_stall();
        i_fetch_stall = 1'b1;
        set_op(6'h00, 5'd7, 32'h0000_0055, 32'h0);
        for (int c = 0; c < 3; c++) begin
            tick();
            vectors++;
            if (o_rd_wr !== 1'b0) begin
                errors++;
                $display("[TB] FAIL stall_hold_%0d: got rd_wr=%b required 0", c, o_rd_wr);
            end
        end
        i_fetch_stall = 1'b0;
        tick();
        set_op(6'h00, 5'd0, 32'h0, 32'h0);
        vectors++;
        if ({o_rd_wr, o_rd_no, o_rd_val} !== {1'b1, 5'd7, 32'h55}) begin
            errors++;
            $display("[TB] FAIL stall_release: got wr=%b no=%0d val=%h required 1 7 00000055",
                     o_rd_wr, o_rd_no, o_rd_val);
        end
        tick();
        vectors++;
        if (o_rd_wr !== 1'b0) begin
            errors++;
            $display("[TB] FAIL stall_single_pulse: got rd_wr=%b required 0", o_rd_wr);
        end
    endtask

    task automatic test_reset_busy();
        set_op(6'h23, 5'd10, 32'h0000_0300, 32'h0);
        tick();
        set_op(6'h00, 5'd0, 32'h0, 32'h0);
        vectors++;
        if ({o_dbus_rd, o_mem_stall} !== 2'b11) begin
            errors++;
            $display("[TB] FAIL rst_busy_req: got rd=%b stall=%b required 1 1", o_dbus_rd, o_mem_stall);
        end
        #2 rst = 1'b1;
        #1;
        test_reset();
        #1 rst = 1'b0;
        i_dbus_ack = 1'b1;
        i_dbus_rdata = 32'hCAFE_F00D;
        tick();
        i_dbus_ack = 1'b0;
        vectors++;
        if ({o_rd_wr, o_rd_no, o_rd_val, o_dbus_rd, o_mem_stall} !== '0) begin
            errors++;
            $display("[TB] FAIL rst_late_ack: got wr=%b no=%0d val=%h rd=%b stall=%b required all 0",
                     o_rd_wr, o_rd_no, o_rd_val, o_dbus_rd, o_mem_stall);
        end
    endtask

    initial begin
        rst = 1'b1;
        i_exec_stall = 1'b0;
        i_fetch_stall = 1'b0;
        i_dbus_ack = 1'b0;
        i_dbus_rdata = 32'h0;
        set_op(6'h00, 5'd0, 32'h0, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        @(negedge clk);
        rst = 1'b0;
        tick();
        test_passthrough();
        test_lw_waits();
        test_load_lanes();
        test_stores();
        test_misaligned();
        test_stall();
        test_reset_busy();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/memory_access.md
# memory_access

Memory-access pipeline stage. It sits directly downstream of the execute stage and consumes its registered outputs: opcode, destination GPR, ALU result/effective address and store data. Loads and stores are issued over a request/acknowledge data bus, with byte-lane steering and sign/zero extension. Non-memory results pass through to writeback, and the stage raises the core-wide memory stall while a bus access is outstanding.

## Interface
- No parameters. Widths: address/data 32, register number 5.
- clk  in  1  core clock.
- rst  in  1  reset; asynchronous, active-high.
- i_exec_stall, i_fetch_stall  in  1 each  stalls from the other stages.
- o_mem_stall  out  1  this stage busy.
- i_op  in  6  opcode from execute.
- i_dst_gpr  in  5  destination register.
- i_result  in  32  ALU result; effective address for loads/stores.
- i_mem_data  in  32  store data (rt value).
- o_dbus_addr  out  32  word address, bits [1:0] always 0.
- o_dbus_rd, o_dbus_wr  out  1 each  read/write request levels.
- o_dbus_ben  out  4  byte enables; bit 3 = bits 31:24.
- o_dbus_wdata  out  32  write data.
- i_dbus_rdata  in  32  read data, valid with ack.
- i_dbus_ack  in  1  request completion.
- o_rd_no  out  5  writeback register.
- o_rd_val  out  32  writeback value.
- o_rd_wr  out  1  writeback strobe.
- o_addr_err  out  1  misaligned-access pulse.
- o_err_addr  out  32  faulting effective address.

## Operation
- core_stall = o_mem_stall | i_exec_stall | i_fetch_stall. Inputs are captured only on a clk edge with core_stall = 0.
- FSM states: IDLE, BUSY. o_mem_stall = (state == BUSY), registered.
- **Non-memory op captured:**
  - o_rd_no ← i_dst_gpr
  - o_rd_val ← i_result
  - o_rd_wr ← (i_dst_gpr != 0)
- **Load/store captured, aligned:**
  - o_dbus_addr ← {i_result[31:2], 2'b00}.
  - Loads set o_dbus_rd; stores set o_dbus_wr.
  - o_rd_wr ← 0; state → BUSY.
- **Opcodes:** LB 0x20, LH 0x21, LW 0x23, LBU 0x24, LHU 0x25, SB 0x28, SH 0x29, SW 0x2B.
- **Alignment:**
  - LH/LHU/SH require addr[0] = 0.
  - LW/SW require addr[1:0] = 0.
  - Violation: no bus request; o_addr_err pulses 1 cycle; o_err_addr ← i_result; o_rd_wr ← 0; state stays IDLE.
- **Big-endian lanes:**
  - Byte at addr[1:0] = k lives in bits [31-8k : 24-8k]; ben = 4'b1000 >> k.
  - Halfword: addr[1] = 0 → bits 31:16, ben 1100; addr[1] = 1 → bits 15:0, ben 0011.
  - Word: ben 1111.
- **Store data:** SB {4{d[7:0]}}, SH {2{d[15:0]}}, SW d.
- **Load extension:**
  - LB/LH sign-extend the selected lane.
  - LBU/LHU zero-extend.
  - LW takes the full word.
  - Load ben follows the same lane rules; the bus may return the full word.
- **BUSY:**
  - Requests and address held stable until i_dbus_ack is sampled high.
  - On the ack edge: o_dbus_rd/o_dbus_wr ← 0, ben ← 0, state → IDLE.
  - Loads on the ack edge: o_rd_no ← captured dst, o_rd_val ← extended data, o_rd_wr ← (dst != 0).
  - Stores on the ack edge: o_rd_wr ← 0.
- i_dbus_ack while IDLE is ignored.
- While IDLE with core_stall = 1: o_rd_wr ← 0, o_addr_err ← 0; all other outputs hold. Each instruction produces at most one writeback strobe.

## Timing
- Reset values: state IDLE; every output 0, including o_mem_stall, requests, ben, addr, wdata, o_rd_*, o_addr_err, o_err_addr.
- Reset mid-BUSY: request dropped immediately (asynchronous); no writeback; a late ack is ignored.
- Non-memory op: o_rd_wr high in the cycle after capture, for 1 cycle.
- Load/store:
  - Request visible in the cycle after capture.
  - With ack in the first BUSY cycle, the writeback strobe appears 2 cycles after capture.
  - Each extra wait cycle adds 1.
- o_mem_stall is high from the cycle after capture through the ack cycle inclusive. The next instruction is captured on the first edge after the ack edge.
- o_rd_wr and o_addr_err are single-cycle pulses and are never both high.

## Test plan
- Passthrough:
  - Stimulus: ADDU op, dst 5, result 0x1234_5678.
  - Response: next cycle o_rd_wr = 1, o_rd_no = 5, o_rd_val = 0x1234_5678, no bus activity.
  - With dst 0: o_rd_wr stays 0.
- LW with waits:
  - Stimulus: LW, addr 0x100, dst 8; ack after 3 BUSY cycles with rdata 0xDEAD_BEEF.
  - Response: o_dbus_rd, addr 0x100, ben 1111 held for 3 cycles; o_mem_stall high 3 cycles; then o_rd_val = 0xDEAD_BEEF, o_rd_wr pulse.
- LB/LBU lanes:
  - Stimulus: addr 0x103, rdata 0x0102_0380.
  - Response: ben 0001; LB → 0xFFFF_FF80; LBU → 0x0000_0080.
- SH:
  - Stimulus: SH, addr 0x202, data 0xAAAA_1234.
  - Response: o_dbus_wr, addr 0x200, ben 0011, wdata 0x1234_1234; no writeback.
- Misaligned:
  - Stimulus: LW at 0x102.
  - Response: o_addr_err pulse, o_err_addr = 0x102, o_dbus_rd stays 0, o_mem_stall stays 0, o_rd_wr 0.
- Stall and reset:
  - i_fetch_stall held 3 cycles with an ADDU input: exactly one o_rd_wr pulse after release.
  - rst asserted mid-BUSY: all outputs 0 at once; a following ack causes no writeback.
